// File: rtl/jtag_tap_sampled_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings and small helpers.
package jtag_tap_sampled_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR        = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR        = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_IDLE         = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   localparam int IDCODE_WIDTH = 32;

   function automatic logic is_shift(input tap_state_e s);
      return (s == SHIFT_IR) || (s == SHIFT_DR);
   endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// Oversamples tck/tms/tdi into clk with equal-depth synchronizers and
// produces one-clk rise/fall strobes from the synchronized tck.
module jtag_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tms_s,
   output logic tdi_s,
   output logic tck_rise,
   output logic tck_fall
);

   logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q;
   logic                   tck_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tck_q <= '0;
         tms_q <= '0;
         tdi_q <= '0;
         tck_d <= 1'b0;
      end else begin
         tck_q <= {tck_q[SYNC_STAGES-2:0], tck};
         tms_q <= {tms_q[SYNC_STAGES-2:0], tms};
         tdi_q <= {tdi_q[SYNC_STAGES-2:0], tdi};
         tck_d <= tck_q[SYNC_STAGES-1];
      end
   end

   // Same depth on all three lines keeps tms/tdi aligned with the tck strobe.
   assign tms_s    = tms_q[SYNC_STAGES-1];
   assign tdi_s    = tdi_q[SYNC_STAGES-1];
   assign tck_rise = tck_q[SYNC_STAGES-1] & ~tck_d;
   assign tck_fall = ~tck_q[SYNC_STAGES-1] & tck_d;

endmodule

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP slave clocked by the system clock: TAP FSM, IR, IDCODE/BYPASS/USER
// data registers and tdo mux, all advanced by oversampled tck strobes.
module jtag_tap_sampled
   import jtag_tap_sampled_pkg::*;
#(
   parameter int                 IR_WIDTH     = 4,
   parameter logic [31:0]        IDCODE_VALUE = 32'h149511C3,
   parameter int                 USER_WIDTH   = 32,
   parameter int                 SYNC_STAGES  = 2,
   parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(4'h1),
   parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(4'h8)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tck,
   input  logic                  tms,
   input  logic                  tdi,
   output logic                  tdo,
   output logic                  tdo_oe,
   input  logic [USER_WIDTH-1:0] user_capture_data,
   output logic [USER_WIDTH-1:0] user_update_data,
   output logic                  user_update_valid,
   output logic [3:0]            tap_state,
   output logic [IR_WIDTH-1:0]   ir_value
);

   logic tms_s, tdi_s, tck_rise, tck_fall;

   jtag_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .tck      (tck),
      .tms      (tms),
      .tdi      (tdi),
      .tms_s    (tms_s),
      .tdi_s    (tdi_s),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall)
   );

   tap_state_e                  state_q, state_d;
   logic [IR_WIDTH-1:0]         ir_sr, ir_q;
   logic [IDCODE_WIDTH-1:0]     id_sr;
   logic                        bp_sr;
   logic [USER_WIDTH-1:0]       usr_sr;
   logic                        sel_id, sel_usr, dr_lsb, tdo_d;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= TEST_LOGIC_RESET;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tck_rise) begin
         case (state_q)
            TEST_LOGIC_RESET: state_d = tms_s ? TEST_LOGIC_RESET : RUN_IDLE;
            RUN_IDLE:         state_d = tms_s ? SELECT_DR : RUN_IDLE;
            SELECT_DR:        state_d = tms_s ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms_s ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         state_d = tms_s ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         state_d = tms_s ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         state_d = tms_s ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         state_d = tms_s ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        state_d = tms_s ? SELECT_DR : RUN_IDLE;
            SELECT_IR:        state_d = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms_s ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         state_d = tms_s ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         state_d = tms_s ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         state_d = tms_s ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         state_d = tms_s ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        state_d = tms_s ? SELECT_DR : RUN_IDLE;
         endcase
      end
   end

   // Any opcode that is neither IDCODE nor USER falls through to BYPASS.
   always_comb begin
      sel_id  = (ir_q == INSTR_IDCODE);
      sel_usr = !sel_id && (ir_q == INSTR_USER);
      dr_lsb  = bp_sr;
      if (sel_id)       dr_lsb = id_sr[0];
      else if (sel_usr) dr_lsb = usr_sr[0];
      tdo_d = 1'b0;
      if (state_q == SHIFT_IR)      tdo_d = ir_sr[0];
      else if (state_q == SHIFT_DR) tdo_d = dr_lsb;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_sr             <= '0;
         ir_q              <= INSTR_IDCODE;
         id_sr             <= '0;
         bp_sr             <= 1'b0;
         usr_sr            <= '0;
         tdo               <= 1'b0;
         tdo_oe            <= 1'b0;
         user_update_data  <= '0;
         user_update_valid <= 1'b0;
      end else begin
         user_update_valid <= 1'b0;
         if (tck_rise) begin
            case (state_q)
               CAPTURE_IR: ir_sr <= IR_WIDTH'(2'b01);
               SHIFT_IR:   ir_sr <= IR_WIDTH'({tdi_s, ir_sr} >> 1);
               CAPTURE_DR: begin
                  if (sel_id)       id_sr  <= IDCODE_VALUE;
                  else if (sel_usr) usr_sr <= user_capture_data;
                  else              bp_sr  <= 1'b0;
               end
               SHIFT_DR: begin
                  if (sel_id)       id_sr  <= {tdi_s, id_sr[IDCODE_WIDTH-1:1]};
                  else if (sel_usr) usr_sr <= USER_WIDTH'({tdi_s, usr_sr} >> 1);
                  else              bp_sr  <= tdi_s;
               end
               default: ;
            endcase
            // Updates fire on entry to the Update/TLR states.
            if (state_d == UPDATE_IR)        ir_q <= ir_sr;
            if (state_d == TEST_LOGIC_RESET) ir_q <= INSTR_IDCODE;
            if (state_d == UPDATE_DR && sel_usr) begin
               user_update_data  <= usr_sr;
               user_update_valid <= 1'b1;
            end
         end else if (tck_fall) begin
            tdo    <= tdo_d;
            tdo_oe <= is_shift(state_q);
         end
      end
   end

   assign tap_state = state_q;
   assign ir_value  = ir_q;

endmodule
